rob_alloc_ctrl: RTL and testbench
=================================

Name: rob_alloc_ctrl

Overview:
- Pointer and occupancy controller for the paired-slot reorder buffer.
- Rename pushes one row per cycle, holding up to two instructions; commit retires up to two entries per cycle in program order.
- Generates `rob_full` and `rob_tail` for rename, and the head entry numbers for commit.
- ROB entry number is `{slot, row}`, with slot 0 for instruction 0 and slot 1 for instruction 1.

Parameters:
- ROB_SIZE, 32: total entries; power of two, at least 4. ROWS = ROB_SIZE/2 and RW = $clog2(ROWS) are derived localparams.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- push_en  in  1  allocate one row at the tail this cycle.
- push_valid0  in  1  slot 0 of the pushed row holds an instruction.
- push_valid1  in  1  slot 1 of the pushed row holds an instruction.
- commit_n  in  2  number of entries retired this cycle (0, 1 or 2), counted from head_num0.
- flush  in  1  discard all entries.
- rob_full  out  1  every row is allocated.
- rob_empty  out  1  no row is allocated.
- rob_tail  out  RW  row index the next push will use.
- head_valid0  out  1  head_num0 is meaningful.
- head_num0  out  RW+1  oldest live entry.
- head_valid1  out  1  head_num1 is meaningful.
- head_num1  out  RW+1  second-oldest live entry.
- rows_used  out  RW+1  allocated row count, 0..ROWS.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Registers: tail_row[RW-1:0], head_row[RW-1:0], head_slot, rows_used, err, and vmask[ROWS][2] holding the per-row slot-valid mask.
- Reset values: all registers 0 on async resetn low. Outputs then read rob_empty=1, rob_full=0, rob_tail=0, head_valid0/1=0, head_num0/1=0, rows_used=0, err=0. vmask is also cleared.
- Combinational outputs: rob_full = (rows_used==ROWS); rob_empty = (rows_used==0); rob_tail = tail_row. No same-cycle bypass of a commit into full.
- Push acceptance: accepted when push_en & ~rob_full & (push_valid0|push_valid1) & ~flush.
  - Effect: vmask[tail_row] <= {push_valid1, push_valid0}; tail_row++, wrapping ROWS-1 to 0; rows_used increments.
- Push rejection:
  - push_en while full: push is ignored and err is set.
  - push_en with both valid bits 0: push is ignored, err is not set.
- Effective head slot: es = head_slot | ~vmask[head_row][0].
- Head entry 0: head_valid0 = ~rob_empty; head_num0 = {es, head_row}.
- Head entry 1:
  - If es==0 and vmask[head_row][1], head_num1 = {1, head_row}.
  - Otherwise, if rows_used>=2, head_num1 = {e', head_row+1}, where e' = ~vmask[head_row+1][0].
  - Otherwise head_valid1 = 0. head_num1 is 0 when not valid.
- Commit of 1 entry:
  - If head entry 1 lies in the same row: head_slot <= 1.
  - Otherwise the row retires: head_row++, head_slot <= 0, rows_used decrements.
- Commit of 2 entries:
  - Same-row pair: row retires.
  - Pair spanning two rows: head row retires. If the next row still has a valid slot after e', that row becomes head with head_slot=1; otherwise it also retires, giving rows_used -= 2 and head_row += 2.
- Commit request exceeding available entries (commit_n > head_valid0 + head_valid1): clamp to the available count and set err. commit_n==3 is treated as 2 plus err.
- Simultaneous push and commit: both apply; rows_used nets out, e.g. +1 and -1 leaves it unchanged. A push into a full ROB is rejected even if a commit frees a row the same cycle.
- Flush priority: flush beats push and commit. head_row, tail_row, head_slot and rows_used all go to 0 next cycle. vmask and err are left untouched.
- err: sticky until reset.
- Latency: all state updates take effect the cycle after the request; outputs are combinational from state.

Optional Feature:
- Macro: ROB_ALLOC_PERF_EN.
- When defined: adds outputs perf_full_stall[31:0] and perf_commit_total[31:0].
  - perf_full_stall counts cycles with push_en & rob_full.
  - perf_commit_total accumulates the clamped commit count.
  - Both saturate at 0xFFFFFFFF, reset to 0, and are not cleared by flush.
- When undefined: the ports and counters are absent.

Test Plan:
- Reset then idle, ROB_SIZE=8: rob_empty=1, rob_full=0, rob_tail=0, rows_used=0, head_valid0=0.
- Four pushes with valid {1,1}, then a fifth push: rob_full=1, rows_used=4, rob_tail=0, and err=1 after the fifth push.
- Push {v0=0, v1=1} then push {1,1}: head_num0={1,0} and head_num1={0,1}. Then commit_n=2: head_num0={1,1} (row 1, slot 1), rows_used=1.
- Push {1,1}, then commit_n=1: head_slot=1, rows_used=1, head_num0={1,0}, head_valid1=0.
- With rows_used=3, assert push, commit_n=2 and flush together: next cycle rows_used=0, rob_tail=0, rob_empty=1.
- Wrap-around: 12 alternating single-row push/commit cycles. rob_tail and head_num0[RW-1:0] cycle 0,1,2,3,0; rows_used never exceeds 1; err stays 0.

Source files
------------

// File: rtl/rob_alloc_if.sv
// Rename/commit-facing bundle for the paired-slot ROB pointer controller.
// The perf counter signals exist only when ROB_ALLOC_PERF_EN is defined.
interface rob_alloc_if #(
    parameter int unsigned ROB_SIZE = 32
);
    localparam int unsigned RW = $clog2(ROB_SIZE / 2);

    logic          push_en;
    logic          push_valid0;
    logic          push_valid1;
    logic [1:0]    commit_n;
    logic          flush;
    logic          rob_full;
    logic          rob_empty;
    logic [RW-1:0] rob_tail;
    logic          head_valid0;
    logic [RW:0]   head_num0;
    logic          head_valid1;
    logic [RW:0]   head_num1;
    logic [RW:0]   rows_used;
    logic          err;
`ifdef ROB_ALLOC_PERF_EN
    logic [31:0]   perf_full_stall;
    logic [31:0]   perf_commit_total;

    modport master (
        output push_en, push_valid0, push_valid1, commit_n, flush,
        input  rob_full, rob_empty, rob_tail, head_valid0, head_num0,
               head_valid1, head_num1, rows_used, err,
               perf_full_stall, perf_commit_total
    );
    modport slave (
        input  push_en, push_valid0, push_valid1, commit_n, flush,
        output rob_full, rob_empty, rob_tail, head_valid0, head_num0,
               head_valid1, head_num1, rows_used, err,
               perf_full_stall, perf_commit_total
    );
`else
    modport master (
        output push_en, push_valid0, push_valid1, commit_n, flush,
        input  rob_full, rob_empty, rob_tail, head_valid0, head_num0,
               head_valid1, head_num1, rows_used, err
    );
    modport slave (
        input  push_en, push_valid0, push_valid1, commit_n, flush,
        output rob_full, rob_empty, rob_tail, head_valid0, head_num0,
               head_valid1, head_num1, rows_used, err
    );
`endif
endinterface

// File: rtl/rob_alloc_ctrl.sv
// Head/tail pointer and occupancy controller for a two-slot-per-row reorder buffer.
// Optional perf counters under ROB_ALLOC_PERF_EN.
module rob_alloc_ctrl #(
    parameter int unsigned ROB_SIZE = 32
) (
    input  logic       clk,
    input  logic       resetn,
    rob_alloc_if.slave rob
);
    localparam int unsigned ROWS = ROB_SIZE / 2;
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned CW   = RW + 1;

    logic [RW-1:0] tail_row_q, tail_row_d;
    logic [RW-1:0] head_row_q, head_row_d;
    logic          head_slot_q, head_slot_d;
    logic [CW-1:0] rows_used_q, rows_used_d;
    logic          err_q, err_d;
    logic [1:0]    vmask_q [ROWS];

    logic          full, empty, es, same_row, e_nxt, nxt_has1;
    logic          hv0, hv1, push_acc, commit_err;
    logic [RW-1:0] row_nxt;
    logic [1:0]    avail, n_eff, retired;

    // Head entry decode from the slot-valid mask of the head and following row
    always_comb begin
        full     = (rows_used_q == CW'(ROWS));
        empty    = (rows_used_q == '0);
        row_nxt  = head_row_q + RW'(1);
        es       = head_slot_q | ~vmask_q[head_row_q][0];
        same_row = ~empty & ~es & vmask_q[head_row_q][1];
        e_nxt    = ~vmask_q[row_nxt][0];
        nxt_has1 = vmask_q[row_nxt][1];
        hv0      = ~empty;
        hv1      = same_row | (rows_used_q >= CW'(2));
    end

    assign rob.rob_full    = full;
    assign rob.rob_empty   = empty;
    assign rob.rob_tail    = tail_row_q;
    assign rob.head_valid0 = hv0;
    assign rob.head_num0   = hv0 ? {es, head_row_q} : '0;
    assign rob.head_valid1 = hv1;
    assign rob.head_num1   = same_row ? {1'b1, head_row_q} :
                             hv1      ? {e_nxt, row_nxt}    : '0;
    assign rob.rows_used   = rows_used_q;
    assign rob.err         = err_q;

    // Next-state: push at tail, clamped commit at head, flush overrides both
    always_comb begin
        tail_row_d  = tail_row_q;
        head_row_d  = head_row_q;
        head_slot_d = head_slot_q;
        rows_used_d = rows_used_q;
        err_d       = err_q;
        retired     = 2'd0;
        avail       = {1'b0, hv0} + {1'b0, hv1};
        commit_err  = (rob.commit_n > avail);
        n_eff       = commit_err ? avail : rob.commit_n;
        push_acc    = rob.push_en & ~full & (rob.push_valid0 | rob.push_valid1) & ~rob.flush;

        case (n_eff)
            2'd1: begin
                if (same_row) begin
                    head_slot_d = 1'b1;
                end else begin
                    head_row_d  = row_nxt;
                    head_slot_d = 1'b0;
                    retired     = 2'd1;
                end
            end
            2'd2: begin
                if (same_row) begin
                    head_row_d  = row_nxt;
                    head_slot_d = 1'b0;
                    retired     = 2'd1;
                end else if (~e_nxt & nxt_has1) begin
                    head_row_d  = row_nxt;
                    head_slot_d = 1'b1;
                    retired     = 2'd1;
                end else begin
                    head_row_d  = row_nxt + RW'(1);
                    head_slot_d = 1'b0;
                    retired     = 2'd2;
                end
            end
            default: ;
        endcase

        if (push_acc) begin
            tail_row_d = tail_row_q + RW'(1);
        end
        rows_used_d = rows_used_q + CW'(push_acc) - CW'(retired);

        if (rob.flush) begin
            tail_row_d  = '0;
            head_row_d  = '0;
            head_slot_d = 1'b0;
            rows_used_d = '0;
        end else begin
            err_d = err_q | (rob.push_en & full) | commit_err;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tail_row_q  <= '0;
            head_row_q  <= '0;
            head_slot_q <= 1'b0;
            rows_used_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                vmask_q[i] <= 2'b00;
            end
        end else begin
            tail_row_q  <= tail_row_d;
            head_row_q  <= head_row_d;
            head_slot_q <= head_slot_d;
            rows_used_q <= rows_used_d;
            err_q       <= err_d;
            if (push_acc) begin
                vmask_q[tail_row_q] <= {rob.push_valid1, rob.push_valid0};
            end
        end
    end

`ifdef ROB_ALLOC_PERF_EN
    logic [31:0] perf_full_stall_q, perf_commit_total_q;
    logic [32:0] commit_sum;

    assign commit_sum            = {1'b0, perf_commit_total_q} + 33'(n_eff);
    assign rob.perf_full_stall   = perf_full_stall_q;
    assign rob.perf_commit_total = perf_commit_total_q;

    // Saturating counters; flush does not clear them
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_full_stall_q   <= '0;
            perf_commit_total_q <= '0;
        end else begin
            if (rob.push_en && full && (perf_full_stall_q != 32'hFFFF_FFFF)) begin
                perf_full_stall_q <= perf_full_stall_q + 32'd1;
            end
            if (!rob.flush) begin
                perf_commit_total_q <= commit_sum[32] ? 32'hFFFF_FFFF : commit_sum[31:0];
            end
        end
    end
`else
`endif
endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Scoreboard bench for rob_alloc_ctrl: an entry-list model predicts outputs per cycle.
module tb_rob_alloc_ctrl;
    localparam int unsigned ROB_SIZE = 8;
    localparam int unsigned ROWS     = ROB_SIZE / 2;

    typedef struct {
        int empty; int full; int tail; int hv0; int hn0;
        int hv1; int hn1; int rows; int err;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    rob_alloc_if #(.ROB_SIZE(ROB_SIZE)) rob ();
    rob_alloc_ctrl #(.ROB_SIZE(ROB_SIZE)) dut (.clk(clk), .resetn(resetn), .rob(rob));

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb_q[$];
    int   ent_q[$];
    int   m_tail;
    int   m_err;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int m_rows();
        int r = 0;
        for (int i = 0; i < ent_q.size(); i++)
            if (i == 0 || (ent_q[i] % ROWS) != (ent_q[i-1] % ROWS)) r++;
        return r;
    endfunction

    task automatic drive(input bit pe, input bit v0, input bit v1, input int cn, input bit fl);
        rob.push_en     = pe;
        rob.push_valid0 = v0;
        rob.push_valid1 = v1;
        rob.commit_n    = 2'(cn);
        rob.flush       = fl;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        resetn = 1'b0;
        #7;
        chk("rst_empty", rob.rob_empty, 1);
        chk("rst_full", rob.rob_full, 0);
        chk("rst_tail", rob.rob_tail, 0);
        chk("rst_hv0", rob.head_valid0, 0);
        chk("rst_hn0", rob.head_num0, 0);
        chk("rst_hv1", rob.head_valid1, 0);
        chk("rst_rows", rob.rows_used, 0);
        chk("rst_err", rob.err, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        ent_q.delete();
        m_tail = 0;
        m_err  = 0;
    endtask

    task automatic compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            chk("rob_empty", rob.rob_empty, e.empty);
            chk("rob_full", rob.rob_full, e.full);
            chk("rob_tail", rob.rob_tail, e.tail);
            chk("head_valid0", rob.head_valid0, e.hv0);
            chk("head_num0", rob.head_num0, e.hn0);
            chk("head_valid1", rob.head_valid1, e.hv1);
            chk("head_num1", rob.head_num1, e.hn1);
            chk("rows_used", rob.rows_used, e.rows);
            chk("err", rob.err, e.err);
        end
    endtask

    // Apply one cycle of stimulus, predict the post-edge outputs, then check them
    task automatic step(input bit pe, input bit v0, input bit v1, input int cn, input bit fl);
        exp_t e;
        int   avail, ncap;
        bit   full;
        drive(pe, v0, v1, cn, fl);
        full  = (m_rows() == ROWS);
        avail = (ent_q.size() > 2) ? 2 : ent_q.size();
        if (fl) begin
            ent_q.delete();
            m_tail = 0;
        end else begin
            if (pe && full) m_err = 1;
            if (cn > avail) m_err = 1;
            ncap = (cn > avail) ? avail : cn;
            repeat (ncap) void'(ent_q.pop_front());
            if (pe && !full && (v0 || v1)) begin
                if (v0) ent_q.push_back(m_tail);
                if (v1) ent_q.push_back(ROWS + m_tail);
                m_tail = (m_tail + 1) % ROWS;
            end
        end
        e.rows  = m_rows();
        e.empty = (e.rows == 0);
        e.full  = (e.rows == ROWS);
        e.tail  = m_tail;
        e.hv0   = (ent_q.size() > 0);
        e.hn0   = (ent_q.size() > 0) ? ent_q[0] : 0;
        e.hv1   = (ent_q.size() > 1);
        e.hn1   = (ent_q.size() > 1) ? ent_q[1] : 0;
        e.err   = m_err;
        sb_q.push_back(e);
        @(posedge clk); #1;
        compare();
    endtask

    initial begin
        do_reset();
        step(0, 0, 0, 0, 0);

        // fill to capacity, then overflow push
        repeat (4) step(1, 1, 1, 0, 0);
        chk("fill_full", rob.rob_full, 1);
        chk("fill_rows", rob.rows_used, 4);
        step(1, 1, 1, 0, 0);
        chk("overflow_err", rob.err, 1);

        // slot-1-only head row, then commit spanning two rows
        do_reset();
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("span_hn0", rob.head_num0, 4);
        chk("span_hn1", rob.head_num1, 1);
        step(0, 0, 0, 2, 0);
        chk("span_after_hn0", rob.head_num0, 5);
        chk("span_after_rows", rob.rows_used, 1);

        // single commit within a full row
        do_reset();
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("half_hn0", rob.head_num0, 4);
        chk("half_hv1", rob.head_valid1, 0);
        step(0, 0, 0, 2, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);

        // flush beats push and commit
        do_reset();
        repeat (3) step(1, 1, 1, 0, 0);
        step(1, 1, 1, 2, 1);
        chk("flush_empty", rob.rob_empty, 1);
        chk("flush_tail", rob.rob_tail, 0);
        step(0, 0, 0, 3, 0);

        // wrap-around with one row in flight
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        chk("wrap_err", rob.err, 0);

        // randomized traffic incl. clamped commits and occasional flush
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
